pc_gen: RTL and testbench
=========================

Name: pc_gen

Overview:
- Fetch-stage PC register with integrated next-PC selection; parametrised successor to the combinational next-PC logic.
- Holds the fetch PC and advances it by 4 each cycle. Applies redirects decided in D (branch, J, JAL, JR) plus exception entry and ERET.
- Buffers a redirect that arrives while fetch is stalled and applies it on stall release.
- Sits between hazard/exception control and instruction memory.

Parameters:
- ADDR_W, 32, PC width; minimum 28.
- RESET_PC, 32'h0000_3000, pc_f value after reset.
- EXC_VEC, 32'h0000_4180, exception entry address.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- stall  in  1  freeze F (and D); pc_f holds.
- npc_sel  in  3  0=SEQ, 1=B, 2=JAL, 3=JR, 4=J; other codes treated as SEQ.
- br_taken  in  1  branch condition from D; used only when npc_sel=B.
- imm26_d  in  26  instr_index / imm16 in [15:0] of the D instruction.
- pc_d  in  ADDR_W  PC of the instruction in D.
- jr_src  in  ADDR_W  forwarded rs value for JR.
- exc_req  in  1  take exception this cycle.
- eret_req  in  1  return from exception.
- epc  in  ADDR_W  ERET target.
- pc_f  out  ADDR_W  current fetch PC, registered.
- pc4_f  out  ADDR_W  pc_f+4, combinational.
- pend_o  out  1  a redirect is buffered (state PEND).
- adel_f  out  1  misaligned fetch flag; see Optional Feature.

Behaviour:
- Reset: when rst_n=0 at a clk edge, pc_f=RESET_PC, state=RUN, pend_o=0, pend_tgt=0, adel_f=0. Reset overrides every other input, including mid-PEND.
- Target computation (combinational, modulo 2^ADDR_W):
  - B: pc_d+4 + (sext(imm26_d[15:0])<<2). Delay slot is preserved.
  - J, JAL: {pc_d[ADDR_W-1:28], imm26_d, 2'b00}.
  - JR: jr_src.
- redir = (npc_sel==B && br_taken) || npc_sel in {JAL, JR, J}.
- State machine: RUN, PEND.
- Update priority each clk edge, highest first:
  1. exc_req: pc_f=EXC_VEC, state=RUN, pending redirect discarded. Ignores stall.
  2. eret_req: pc_f=epc, state=RUN, pending discarded. Ignores stall.
  3. RUN, redir, stall=0: pc_f=target. Latency 1 cycle.
  4. RUN, redir, stall=1: pend_tgt=target, state=PEND, pc_f holds.
  5. PEND, stall=1: hold everything. redir/npc_sel are ignored because the D instruction is frozen and the target is already captured.
  6. PEND, stall=0: pc_f=pend_tgt, state=RUN.
  7. RUN, stall=1: hold.
  8. Otherwise: pc_f=pc_f+4.
- pend_o = (state==PEND).
- Wrap-around: pc_f+4 at all-ones-minus-3 wraps to 0 with no flag.
- A not-taken branch behaves as SEQ.
- exc_req and eret_req together: exc_req wins.

Optional Feature:
- Macro PC_ALIGN_CHK_EN.
- Defined:
  - Any value loaded into pc_f (JR, ERET or pend_tgt) with bits[1:0]!=0 is loaded unchanged, and adel_f=1 registered alongside it.
  - adel_f clears on the next pc_f load; exception logic consumes it.
- Undefined:
  - JR and ERET targets have bits[1:0] forced to 0.
  - adel_f is tied 0.

Test Plan:
- Reset, then 3 free-running cycles -> pc_f 3000, 3004, 3008, 300C; pend_o=0.
- pc_d=3010, npc_sel=B, br_taken=1, imm=16'hFFFC -> next pc_f=3004. Same with br_taken=0 -> pc_f+4.
- npc_sel=JR, jr_src=0000_5000, stall=1 for 2 cycles -> pc_f held, pend_o=1. stall=0 -> pc_f=5000, pend_o=0.
- State PEND plus exc_req=1 and stall=1 -> pc_f=4180, pend_o=0. Following cycle -> 4184.
- npc_sel=J, pc_d=3000, imm26=26'h0000_C40 -> pc_f=0000_3100. pc_f=FFFF_FFFC free-running -> 0000_0000.
- With PC_ALIGN_CHK_EN: JR to 0000_5002 -> pc_f=5002, adel_f=1. Without it -> pc_f=5000, adel_f=0.

Source files
------------

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch-stage PC register with next-PC select and stalled-redirect buffer
// Optional misaligned-fetch flag adel_f is enabled by defining PC_ALIGN_CHK_EN.
module pc_gen #(
   parameter int unsigned       ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h0000_3000),
   parameter logic [ADDR_W-1:0] EXC_VEC  = ADDR_W'(32'h0000_4180)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall,
   input  logic [2:0]        npc_sel,
   input  logic              br_taken,
   input  logic [25:0]       imm26_d,
   input  logic [ADDR_W-1:0] pc_d,
   input  logic [ADDR_W-1:0] jr_src,
   input  logic              exc_req,
   input  logic              eret_req,
   input  logic [ADDR_W-1:0] epc,
   output logic [ADDR_W-1:0] pc_f,
   output logic [ADDR_W-1:0] pc4_f,
   output logic              pend_o,
   output logic              adel_f
);

   localparam logic [2:0] SEL_B   = 3'd1;
   localparam logic [2:0] SEL_JAL = 3'd2;
   localparam logic [2:0] SEL_JR  = 3'd3;
   localparam logic [2:0] SEL_J   = 3'd4;

   typedef enum logic {ST_RUN, ST_PEND} state_t;

   state_t            r_state, w_state_nxt;
   logic [ADDR_W-1:0] r_pc, r_pend_tgt;
   logic [ADDR_W-1:0] w_pc4, w_pc_nxt, w_tgt;
   logic [ADDR_W-1:0] w_br_tgt, w_j_tgt, w_jr_tgt, w_epc_tgt;
   logic              w_redir, w_pc_load, w_tgt_load;

   assign w_pc4    = r_pc + ADDR_W'(4);
   assign w_br_tgt = pc_d + ADDR_W'(4) + {{(ADDR_W-18){imm26_d[15]}}, imm26_d[15:0], 2'b00};

   generate
      if (ADDR_W > 28) begin : g_j_hi
         assign w_j_tgt = {pc_d[ADDR_W-1:28], imm26_d, 2'b00};
      end else begin : g_j_lo
         assign w_j_tgt = {imm26_d, 2'b00};
      end
   endgenerate

`ifdef PC_ALIGN_CHK_EN
   assign w_jr_tgt  = jr_src;
   assign w_epc_tgt = epc;
`else
   // Without the alignment check, register-sourced targets are silently word-aligned.
   assign w_jr_tgt  = jr_src & ~ADDR_W'(3);
   assign w_epc_tgt = epc & ~ADDR_W'(3);
`endif

   always_comb begin
      w_tgt   = w_br_tgt;
      w_redir = 1'b0;
      case (npc_sel)
         SEL_B:          begin w_tgt = w_br_tgt; w_redir = br_taken; end
         SEL_JAL, SEL_J: begin w_tgt = w_j_tgt;  w_redir = 1'b1;     end
         SEL_JR:         begin w_tgt = w_jr_tgt; w_redir = 1'b1;     end
         default:        ;
      endcase
   end

   // State register (with the PC and buffered target it governs)
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= ST_RUN;
         r_pc       <= RESET_PC;
         r_pend_tgt <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_pc_load)  r_pc       <= w_pc_nxt;
         if (w_tgt_load) r_pend_tgt <= w_tgt;
      end
   end

   // Next-state logic; exception and ERET override stall and any pending redirect
   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = w_pc4;
      w_pc_load   = 1'b0;
      w_tgt_load  = 1'b0;
      if (exc_req) begin
         w_pc_nxt    = EXC_VEC;
         w_pc_load   = 1'b1;
         w_state_nxt = ST_RUN;
      end else if (eret_req) begin
         w_pc_nxt    = w_epc_tgt;
         w_pc_load   = 1'b1;
         w_state_nxt = ST_RUN;
      end else if (r_state == ST_PEND) begin
         if (!stall) begin
            w_pc_nxt    = r_pend_tgt;
            w_pc_load   = 1'b1;
            w_state_nxt = ST_RUN;
         end
      end else if (w_redir) begin
         if (stall) begin
            w_tgt_load  = 1'b1;
            w_state_nxt = ST_PEND;
         end else begin
            w_pc_nxt  = w_tgt;
            w_pc_load = 1'b1;
         end
      end else if (!stall) begin
         w_pc_load = 1'b1;
      end
   end

   // Output logic
   always_comb begin
      pc_f   = r_pc;
      pc4_f  = w_pc4;
      pend_o = (r_state == ST_PEND);
   end

`ifdef PC_ALIGN_CHK_EN
   logic r_adel;
   logic w_adel_nxt;

   // Sequential and exception loads are always aligned; only redirect-style loads can flag.
   assign w_adel_nxt = !exc_req && (eret_req || (r_state == ST_PEND) || w_redir)
                       && (w_pc_nxt[1:0] != 2'b00);

   always_ff @(posedge clk) begin
      if (!rst_n)         r_adel <= 1'b0;
      else if (w_pc_load) r_adel <= w_adel_nxt;
   end

   assign adel_f = r_adel;
`else
   assign adel_f = 1'b0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - directed and randomized self-checking bench for pc_gen
module tb_pc_gen;

   localparam logic [31:0] RESET_PC = 32'h0000_3000;
   localparam logic [31:0] EXC_VEC  = 32'h0000_4180;
   localparam logic [2:0]  SEQ = 3'd0, BR = 3'd1, JAL = 3'd2, JR = 3'd3, JMP = 3'd4;

   logic        clk = 1'b0;
   logic        rst_n, stall, br_taken, exc_req, eret_req;
   logic [2:0]  npc_sel;
   logic [25:0] imm26_d;
   logic [31:0] pc_d, jr_src, epc;
   logic [31:0] pc_f, pc4_f;
   logic        pend_o, adel_f;

   int checks = 0;
   int errors = 0;

   logic [31:0] m_pc = RESET_PC;
   logic [31:0] m_tgt = '0;
   bit          m_pend = 0;
   bit          m_adel = 0;

   pc_gen dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .npc_sel(npc_sel), .br_taken(br_taken),
      .imm26_d(imm26_d), .pc_d(pc_d), .jr_src(jr_src), .exc_req(exc_req),
      .eret_req(eret_req), .epc(epc), .pc_f(pc_f), .pc4_f(pc4_f), .pend_o(pend_o),
      .adel_f(adel_f)
   );

   always #5 clk = ~clk;

   // Load of a register-sourced or buffered target into the model PC.
   task automatic m_load(input logic [31:0] v);
`ifdef PC_ALIGN_CHK_EN
      m_pc   = v;
      m_adel = (v % 4) != 0;
`else
      m_pc   = v - (v % 4);
      m_adel = 0;
`endif
   endtask

   task automatic model_step();
      logic signed [15:0] off;
      logic [31:0] t;
      bit redir;
      off   = imm26_d[15:0];
      t     = pc_d + 32'd4 + 32'(int'(off) * 4);
      redir = 0;
      if (npc_sel == BR && br_taken) redir = 1;
      if (npc_sel == JAL || npc_sel == JMP) begin t = (pc_d & 32'hF000_0000) | (32'(imm26_d) * 4); redir = 1; end
      if (npc_sel == JR) begin t = jr_src; redir = 1; end
      if (!rst_n) begin
         m_pc = RESET_PC; m_pend = 0; m_tgt = '0; m_adel = 0;
      end else if (exc_req) begin
         m_pc = EXC_VEC; m_pend = 0; m_adel = 0;
      end else if (eret_req) begin
         m_load(epc); m_pend = 0;
      end else if (m_pend) begin
         if (!stall) begin m_load(m_tgt); m_pend = 0; end
      end else if (redir) begin
         if (stall) begin m_tgt = t; m_pend = 1; end
         else m_load(t);
      end else if (!stall) begin
         m_pc = m_pc + 32'd4; m_adel = 0;
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rst_n = 1; stall = 0; npc_sel = SEQ; br_taken = 0; imm26_d = '0;
      pc_d = '0; jr_src = '0; exc_req = 0; eret_req = 0; epc = '0;
   endtask

   task automatic test_reset();
      logic [31:0] exp_pc;
      idle(); rst_n = 0; tick(); tick();
      checks++; if (pc_f !== RESET_PC) begin errors++; $display("FAIL reset_pc got %h want %h", pc_f, RESET_PC); end
      checks++; if (pend_o !== 1'b0) begin errors++; $display("FAIL reset_pend got %b want 0", pend_o); end
      checks++; if (adel_f !== 1'b0) begin errors++; $display("FAIL reset_adel got %b want 0", adel_f); end
      rst_n = 1;
      exp_pc = RESET_PC;
      for (int i = 0; i < 3; i++) begin
         tick(); exp_pc = exp_pc + 32'd4;
         checks++; if (pc_f !== exp_pc) begin errors++; $display("FAIL seq_pc[%0d] got %h want %h", i, pc_f, exp_pc); end
         checks++; if (pc4_f !== exp_pc + 32'd4) begin errors++; $display("FAIL seq_pc4[%0d] got %h want %h", i, pc4_f, exp_pc + 32'd4); end
      end
   endtask

   task automatic test_branch();
      idle(); pc_d = 32'h3010; npc_sel = BR; br_taken = 1; imm26_d = 26'h000_FFFC; tick();
      checks++; if (pc_f !== 32'h3004) begin errors++; $display("FAIL br_taken got %h want %h", pc_f, 32'h3004); end
      br_taken = 0; tick();
      checks++; if (pc_f !== 32'h3008) begin errors++; $display("FAIL br_not_taken got %h want %h", pc_f, 32'h3008); end
   endtask

   task automatic test_jr_stall();
      idle(); npc_sel = JR; jr_src = 32'h5000; stall = 1;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++; if (pc_f !== 32'h3008) begin errors++; $display("FAIL jr_stall_hold[%0d] got %h want %h", i, pc_f, 32'h3008); end
         checks++; if (pend_o !== 1'b1) begin errors++; $display("FAIL jr_stall_pend[%0d] got %b want 1", i, pend_o); end
      end
      stall = 0; npc_sel = SEQ; tick();
      checks++; if (pc_f !== 32'h5000) begin errors++; $display("FAIL jr_release got %h want %h", pc_f, 32'h5000); end
      checks++; if (pend_o !== 1'b0) begin errors++; $display("FAIL jr_release_pend got %b want 0", pend_o); end
   endtask

   task automatic test_exc_in_pend();
      idle(); npc_sel = JR; jr_src = 32'h6000; stall = 1; tick();
      exc_req = 1; tick();
      checks++; if (pc_f !== EXC_VEC) begin errors++; $display("FAIL exc_pend_pc got %h want %h", pc_f, EXC_VEC); end
      checks++; if (pend_o !== 1'b0) begin errors++; $display("FAIL exc_pend_flag got %b want 0", pend_o); end
      idle(); tick();
      checks++; if (pc_f !== 32'h4184) begin errors++; $display("FAIL exc_next got %h want %h", pc_f, 32'h4184); end
      npc_sel = JR; jr_src = 32'h6000; stall = 1; tick();
      rst_n = 0; tick();
      checks++; if (pc_f !== RESET_PC || pend_o !== 1'b0) begin errors++; $display("FAIL reset_in_pend got %h/%b want %h/0", pc_f, pend_o, RESET_PC); end
      idle(); exc_req = 1; eret_req = 1; epc = 32'h7000; tick();
      checks++; if (pc_f !== EXC_VEC) begin errors++; $display("FAIL exc_over_eret got %h want %h", pc_f, EXC_VEC); end
   endtask

   task automatic test_j_wrap();
      idle(); npc_sel = JMP; pc_d = 32'h3000; imm26_d = 26'h000_0C40; tick();
      checks++; if (pc_f !== 32'h3100) begin errors++; $display("FAIL j_target got %h want %h", pc_f, 32'h3100); end
      idle(); npc_sel = JR; jr_src = 32'hFFFF_FFFC; tick();
      idle(); tick();
      checks++; if (pc_f !== 32'h0) begin errors++; $display("FAIL wrap got %h want %h", pc_f, 32'h0); end
   endtask

   task automatic test_align();
      logic [31:0] exp_pc, exp_epc;
      bit exp_adel;
`ifdef PC_ALIGN_CHK_EN
      exp_pc = 32'h5002; exp_epc = 32'h7002; exp_adel = 1;
`else
      exp_pc = 32'h5000; exp_epc = 32'h7000; exp_adel = 0;
`endif
      idle(); npc_sel = JR; jr_src = 32'h5002; tick();
      checks++; if (pc_f !== exp_pc) begin errors++; $display("FAIL jr_align_pc got %h want %h", pc_f, exp_pc); end
      checks++; if (adel_f !== exp_adel) begin errors++; $display("FAIL jr_align_adel got %b want %b", adel_f, exp_adel); end
      idle(); tick();
      checks++; if (adel_f !== 1'b0) begin errors++; $display("FAIL adel_clear got %b want 0", adel_f); end
      idle(); eret_req = 1; epc = 32'h7002; stall = 1; tick();
      checks++; if (pc_f !== exp_epc || adel_f !== exp_adel) begin errors++; $display("FAIL eret_align got %h/%b want %h/%b", pc_f, adel_f, exp_epc, exp_adel); end
   endtask

   task automatic test_back_to_back();
      idle(); npc_sel = JAL; pc_d = 32'h1000_0000; imm26_d = 26'h000_0100; tick();
      checks++; if (pc_f !== 32'h1000_0400) begin errors++; $display("FAIL b2b_jal got %h want %h", pc_f, 32'h1000_0400); end
      npc_sel = JR; jr_src = 32'h2000; tick();
      checks++; if (pc_f !== 32'h2000) begin errors++; $display("FAIL b2b_jr got %h want %h", pc_f, 32'h2000); end
      npc_sel = BR; br_taken = 1; pc_d = 32'h2000; imm26_d = 26'h000_0010; tick();
      checks++; if (pc_f !== 32'h2044) begin errors++; $display("FAIL b2b_br got %h want %h", pc_f, 32'h2044); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         rst_n    = ($urandom_range(63) != 0);
         stall    = ($urandom_range(4) < 2);
         npc_sel  = 3'($urandom_range(7));
         br_taken = 1'($urandom);
         imm26_d  = 26'($urandom);
         pc_d     = $urandom & 32'hFFFF_FFFC;
         jr_src   = $urandom;
         exc_req  = ($urandom_range(15) == 0);
         eret_req = ($urandom_range(15) == 0);
         epc      = $urandom;
         tick();
         checks++; if (pc_f !== m_pc) begin errors++; $display("FAIL rand_pc[%0d] got %h want %h", i, pc_f, m_pc); end
         checks++; if (pc4_f !== m_pc + 32'd4) begin errors++; $display("FAIL rand_pc4[%0d] got %h want %h", i, pc4_f, m_pc + 32'd4); end
         checks++; if (pend_o !== m_pend) begin errors++; $display("FAIL rand_pend[%0d] got %b want %b", i, pend_o, m_pend); end
         checks++; if (adel_f !== m_adel) begin errors++; $display("FAIL rand_adel[%0d] got %b want %b", i, adel_f, m_adel); end
      end
   endtask

   initial begin
      idle();
      test_reset();
      test_branch();
      test_jr_stall();
      test_exc_in_pend();
      test_j_wrap();
      test_align();
      test_back_to_back();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
